// File: rtl/chip_protocol_sequencer.sv
// Purpose: sequences one ChIP ring operation (LOAD -> MIX -> COLLECT -> DONE) on the pad valves and pump.
// Latency: start sampled at edge N gives LOAD at N+1; done pulses at N+1+L+3*PUMP_DIV*M+L.
// Backpressure: none; start is only accepted in IDLE and abort (level) forces IDLE from any state.
//
// Ports:
//   clk, rst (sync, active-high)          clock and reset
//   start, inlet_sel, ring_sel,           command strobe and its operands, latched in IDLE
//   load_time, mix_cycles
//   abort                                 level, returns to IDLE with all outputs off
//   busy, done, err, state                status (done/err are 1-cycle pulses)
//   ctrl_inlet, ctrl_ring                 one-hot inlet / ring valves
//   ctrl_stage_in/out, ctrl_sieve,        stage, sieve and collect valves
//   ctrl_collect
//   pump                                  3-phase peristaltic pump lines
module chip_protocol_sequencer #(
    parameter int SIZE      = 4,
    parameter int NUM_INLET = 5,
    parameter int PUMP_DIV  = 8,
    parameter int CNT_W     = 16,
    localparam int RING_W   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           inlet_sel,
    input  logic [RING_W-1:0]    ring_sel,
    input  logic [CNT_W-1:0]     load_time,
    input  logic [CNT_W-1:0]     mix_cycles,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [2:0]           state,
    output logic [NUM_INLET-1:0] ctrl_inlet,
    output logic [SIZE-1:0]      ctrl_ring,
    output logic                 ctrl_stage_in,
    output logic                 ctrl_stage_out,
    output logic                 ctrl_sieve,
    output logic                 ctrl_collect,
    output logic [2:0]           pump
);

    localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PUMP_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_MIX     = 3'd2,
        S_COLLECT = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;        // dwell counter for LOAD / COLLECT
    logic [DIV_W-1:0]     div_q, div_d;        // clocks within the current pump phase
    logic [1:0]           phase_q, phase_d;    // pump phase index 0..2
    logic [CNT_W-1:0]     rot_q, rot_d;        // completed pump rotations in MIX

    logic [2:0]           cmd_inlet_q, cmd_inlet_d;
    logic [RING_W-1:0]    cmd_ring_q, cmd_ring_d;
    logic [CNT_W-1:0]     cmd_load_q, cmd_load_d;
    logic [CNT_W-1:0]     cmd_mix_q, cmd_mix_d;

    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [NUM_INLET-1:0] ctrl_inlet_q, ctrl_inlet_d;
    logic [SIZE-1:0]      ctrl_ring_q, ctrl_ring_d;
    logic                 stage_in_q, stage_in_d;
    logic                 stage_out_q, stage_out_d;
    logic                 sieve_q, sieve_d;
    logic                 collect_q, collect_d;
    logic [2:0]           pump_q, pump_d;

    logic                 bad_cmd;
    logic [CNT_W-1:0]     dwell_last;
    logic                 pumping_d;

    // Indices outside the valve arrays would drive no valve at all; reject them up front.
    assign bad_cmd = (32'(inlet_sel) >= 32'(NUM_INLET)) || (32'(ring_sel) >= 32'(SIZE));

    // A zero dwell behaves as one clock.
    assign dwell_last = (cmd_load_q == '0) ? '0 : cmd_load_q - 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        div_d       = div_q + 1'b1;
        phase_d     = phase_q;
        rot_d       = rot_q;
        cmd_inlet_d = cmd_inlet_q;
        cmd_ring_d  = cmd_ring_q;
        cmd_load_d  = cmd_load_q;
        cmd_mix_d   = cmd_mix_q;
        err_d       = 1'b0;

        // Pump divider: phase advances every PUMP_DIV clocks, rotation counts phase wraps.
        if (div_q == DIV_MAX) begin
            div_d = '0;
            if (phase_q == 2'd2) begin
                phase_d = 2'd0;
                rot_d   = rot_q + 1'b1;
            end else begin
                phase_d = phase_q + 2'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    cmd_inlet_d = inlet_sel;
                    cmd_ring_d  = ring_sel;
                    cmd_load_d  = load_time;
                    cmd_mix_d   = mix_cycles;
                    if (bad_cmd) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (cnt_q == dwell_last) begin
                    state_d = (cmd_mix_q == '0) ? S_COLLECT : S_MIX;
                end
            end
            S_MIX: begin
                // Last clock of the last phase of the last rotation.
                if ((rot_q == cmd_mix_q - 1'b1) && (phase_q == 2'd2) && (div_q == DIV_MAX)) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (cnt_q == dwell_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            err_d   = 1'b0;
        end

        // Every state entry (and idle time) restarts dwell, divider, phase and rotation count.
        if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_DONE)) begin
            cnt_d   = '0;
            div_d   = '0;
            phase_d = 2'd0;
            rot_d   = '0;
        end

        // Outputs are decoded from the next state so they are valid in a state's first cycle.
        pumping_d   = (state_d == S_LOAD) || (state_d == S_MIX) || (state_d == S_COLLECT);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        ctrl_inlet_d = (state_d == S_LOAD) ? (NUM_INLET'(1) << cmd_inlet_d) : '0;
        ctrl_ring_d  = pumping_d ? (SIZE'(1) << cmd_ring_d) : '0;
        stage_in_d  = (state_d == S_LOAD);
        stage_out_d = (state_d == S_COLLECT);
        sieve_d     = (state_d == S_COLLECT);
        collect_d   = (state_d == S_COLLECT);
        pump_d      = 3'b000;
        if (pumping_d) begin
            case (phase_d)
                2'd0:    pump_d = 3'b110;
                2'd1:    pump_d = 3'b011;
                default: pump_d = 3'b101;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            div_q        <= '0;
            phase_q      <= 2'd0;
            rot_q        <= '0;
            cmd_inlet_q  <= '0;
            cmd_ring_q   <= '0;
            cmd_load_q   <= '0;
            cmd_mix_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ctrl_inlet_q <= '0;
            ctrl_ring_q  <= '0;
            stage_in_q   <= 1'b0;
            stage_out_q  <= 1'b0;
            sieve_q      <= 1'b0;
            collect_q    <= 1'b0;
            pump_q       <= 3'b000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            phase_q      <= phase_d;
            rot_q        <= rot_d;
            cmd_inlet_q  <= cmd_inlet_d;
            cmd_ring_q   <= cmd_ring_d;
            cmd_load_q   <= cmd_load_d;
            cmd_mix_q    <= cmd_mix_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            ctrl_inlet_q <= ctrl_inlet_d;
            ctrl_ring_q  <= ctrl_ring_d;
            stage_in_q   <= stage_in_d;
            stage_out_q  <= stage_out_d;
            sieve_q      <= sieve_d;
            collect_q    <= collect_d;
            pump_q       <= pump_d;
        end
    end

    assign state          = state_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign ctrl_inlet     = ctrl_inlet_q;
    assign ctrl_ring      = ctrl_ring_q;
    assign ctrl_stage_in  = stage_in_q;
    assign ctrl_stage_out = stage_out_q;
    assign ctrl_sieve     = sieve_q;
    assign ctrl_collect   = collect_q;
    assign pump           = pump_q;

endmodule

// File: tb/tb_chip_protocol_sequencer.sv
// Purpose: directed self-checking bench for chip_protocol_sequencer (SIZE=4, NUM_INLET=5, PUMP_DIV=8).
// Latency: expected outputs per cycle come from the documented state durations and pump table.
// Backpressure: none; inputs driven and outputs sampled on the falling edge.
module tb_chip_protocol_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  inlet_sel;
    logic [1:0]  ring_sel;
    logic [15:0] load_time;
    logic [15:0] mix_cycles;
    logic        abort;
    logic        busy, done, err;
    logic [2:0]  state;
    logic [4:0]  ctrl_inlet;
    logic [3:0]  ctrl_ring;
    logic        ctrl_stage_in, ctrl_stage_out, ctrl_sieve, ctrl_collect;
    logic [2:0]  pump;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    chip_protocol_sequencer #(
        .SIZE(4), .NUM_INLET(5), .PUMP_DIV(8), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .inlet_sel(inlet_sel), .ring_sel(ring_sel),
        .load_time(load_time), .mix_cycles(mix_cycles), .abort(abort),
        .busy(busy), .done(done), .err(err), .state(state),
        .ctrl_inlet(ctrl_inlet), .ctrl_ring(ctrl_ring),
        .ctrl_stage_in(ctrl_stage_in), .ctrl_stage_out(ctrl_stage_out),
        .ctrl_sieve(ctrl_sieve), .ctrl_collect(ctrl_collect), .pump(pump)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [2:0] pump_of(input int j);
        case ((j / 8) % 3)
            0:       return 3'b110;
            1:       return 3'b011;
            default: return 3'b101;
        endcase
    endfunction

    // Issues one command and checks every output on every cycle k after the start edge.
    // poke_k: cycle at which a stray start is driven; kill_k: cycle at which abort
    // (or a 2-clock rst when kill_rst) is driven. 0 disables either.
    task automatic run_seq(input int inl, input int rg, input int lt, input int mc,
                           input int poke_k, input int kill_k, input bit kill_rst);
        int le, mx, last, j;
        logic [2:0]  es;
        logic [31:0] e_inl, e_ring, e_valve, e_pump;
        bit dead;
        le   = (lt == 0) ? 1 : lt;
        mx   = 24 * mc;
        last = 2 * le + mx + 1;
        dead = 1'b0;
        inlet_sel  = 3'(inl);
        ring_sel   = 2'(rg);
        load_time  = 16'(lt);
        mix_cycles = 16'(mc);
        start      = 1'b1;
        tick;
        for (int k = 1; k <= last + 1; k++) begin
            // Command inputs change after the latch and must be ignored.
            inlet_sel  = 3'd0;
            ring_sel   = 2'd3;
            load_time  = 16'd7;
            mix_cycles = 16'd5;
            j = 0;
            if (dead)                   es = 3'd0;
            else if (k <= le)           begin es = 3'd1; j = k - 1;           end
            else if (k <= le + mx)      begin es = 3'd2; j = k - le - 1;      end
            else if (k <= 2 * le + mx)  begin es = 3'd3; j = k - le - mx - 1; end
            else if (k == last)         es = 3'd4;
            else                        es = 3'd0;
            e_inl   = (es == 3'd1) ? (32'd1 << inl) : 32'd0;
            e_ring  = (es >= 3'd1 && es <= 3'd3) ? (32'd1 << rg) : 32'd0;
            e_valve = (es == 3'd1) ? 32'h8 : ((es == 3'd3) ? 32'h7 : 32'h0);
            e_pump  = (es >= 3'd1 && es <= 3'd3) ? 32'(pump_of(j)) : 32'd0;
            check("state", 32'(state), 32'(es));
            check("busy",  32'(busy),  32'(es != 3'd0));
            check("done",  32'(done),  32'(es == 3'd4));
            check("err",   32'(err),   32'd0);
            check("inlet", 32'(ctrl_inlet), e_inl);
            check("ring",  32'(ctrl_ring),  e_ring);
            check("valves", 32'({ctrl_stage_in, ctrl_stage_out, ctrl_sieve, ctrl_collect}), e_valve);
            check("pump",  32'(pump), e_pump);
            start = (k == poke_k);
            abort = !kill_rst && (k == kill_k);
            rst   = kill_rst && ((k == kill_k) || (k == kill_k + 1));
            if (k == kill_k) dead = 1'b1;
            if (dead && k >= kill_k + 2) break;
            tick;
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        inlet_sel = 3'd0; ring_sel = 2'd0; load_time = 16'd0; mix_cycles = 16'd0;
        @(negedge clk);
        tick;
        check("rst_state", 32'(state), 32'd0);
        check("rst_outs", 32'({busy, done, err, ctrl_inlet, ctrl_ring, ctrl_stage_in,
                               ctrl_stage_out, ctrl_sieve, ctrl_collect, pump}), 32'd0);
        rst = 1'b0;
        tick;

        // Nominal run with pump phase checks: 4 + 48 + 4, done at cycle 57.
        run_seq(2, 1, 4, 2, 0, 0, 1'b0);
        // Zero dwell and skipped MIX: done at cycle 3.
        run_seq(0, 3, 0, 0, 0, 0, 1'b0);

        // Out-of-range inlet is rejected.
        inlet_sel = 3'd5; ring_sel = 2'd0; load_time = 16'd2; mix_cycles = 16'd1; start = 1'b1;
        tick;
        start = 1'b0;
        check("rej_err",   32'(err),   32'd1);
        check("rej_busy",  32'(busy),  32'd0);
        check("rej_state", 32'(state), 32'd0);
        tick;
        check("rej_err_pulse", 32'(err), 32'd0);

        // start together with abort is dropped.
        inlet_sel = 3'd1; start = 1'b1; abort = 1'b1;
        tick;
        start = 1'b0; abort = 1'b0;
        check("abort_start_state", 32'(state), 32'd0);
        check("abort_start_busy",  32'(busy),  32'd0);

        // Stray start during MIX changes nothing.
        run_seq(2, 1, 4, 2, 20, 0, 1'b0);
        // rst held 2 clocks in COLLECT.
        run_seq(1, 0, 4, 0, 0, 6, 1'b1);
        tick;
        // Abort at MIX clock 10, then an immediate new command.
        run_seq(2, 1, 4, 2, 0, 15, 1'b0);
        run_seq(4, 2, 2, 1, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
